// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared VPU SRAM constants, request type and address decode helpers
package vpu_pkg;

    localparam int SRAM_R_PORT_CNT     = 3;
    localparam int SRAM_BANK_CNT       = 4;
    localparam int OPERAND_ADDR_WIDTH  = 24;
    localparam int SRAM_DATA_WIDTH     = 512;
    localparam int SRAM_BANK_DEPTH_LG2 = 10;
    localparam int SRAM_BANK_ID_W      = 2;

    typedef struct packed {
        logic                          valid;
        logic [OPERAND_ADDR_WIDTH-1:0] addr;
    } vpu_sram_rd_req_t;

    // Banks interleave on 512-byte blocks: addr[10:9] selects the bank.
    function automatic logic [SRAM_BANK_ID_W-1:0] get_bank_id(
        input logic [OPERAND_ADDR_WIDTH-1:0] addr
    );
        return addr[10:9];
    endfunction

    // Row inside the bank; addr[23:21] lies outside the SRAM and is dropped.
    function automatic logic [SRAM_BANK_DEPTH_LG2-1:0] get_raddr(
        input logic [OPERAND_ADDR_WIDTH-1:0] addr
    );
        return addr[20:11];
    endfunction

endpackage

// File: rtl/vpu_rr_arb.sv
// rtl/vpu_rr_arb.sv - N-way round-robin arbiter with registered priority pointer
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   gnt        : one-hot grant (zero when no request)
module vpu_rr_arb #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;
    int            k;

    // Scan from the pointer upward with wrap; first requester wins.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                win    = PW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(win) == N - 1) ? '0 : win + PW'(1);
        end
    end

endmodule

// File: rtl/vpu_sram_rd_arb.sv
// rtl/vpu_sram_rd_arb.sv - per-bank round-robin read arbiter between VPU requesters and SRAM banks
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_valid_i/req_addr_i/req_ready_o : per-requester request handshake
//   rsp_valid_o/rsp_data_o             : per-requester read data, one cycle after handshake
//   bank_ren_o/bank_raddr_o/bank_rdata_i : SRAM bank read ports (data one cycle after ren)
//   Macro VPU_RD_ARB_MERGE_EN: grant same-bank same-row requests together on one ren.
module vpu_sram_rd_arb
    import vpu_pkg::*;
#(
    parameter int PORT_CNT = SRAM_R_PORT_CNT,
    parameter int BANK_CNT = SRAM_BANK_CNT,
    parameter int ADDR_W   = OPERAND_ADDR_WIDTH,
    parameter int DATA_W   = SRAM_DATA_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [PORT_CNT-1:0]                   req_valid_i,
    input  logic [PORT_CNT*ADDR_W-1:0]            req_addr_i,
    output logic [PORT_CNT-1:0]                   req_ready_o,
    output logic [PORT_CNT-1:0]                   rsp_valid_o,
    output logic [PORT_CNT*DATA_W-1:0]            rsp_data_o,
    output logic [BANK_CNT-1:0]                   bank_ren_o,
    output logic [BANK_CNT*SRAM_BANK_DEPTH_LG2-1:0] bank_raddr_o,
    input  logic [BANK_CNT*DATA_W-1:0]            bank_rdata_i
);
    localparam int ROW_W = SRAM_BANK_DEPTH_LG2;
    localparam int BID_W = SRAM_BANK_ID_W;

    vpu_sram_rd_req_t   req      [PORT_CNT];
    logic [BID_W-1:0]   bank_id  [PORT_CNT];
    logic [ROW_W-1:0]   row      [PORT_CNT];
    logic [BID_W-1:0]   bank_sel [PORT_CNT];
    logic [PORT_CNT-1:0] bank_gnt [BANK_CNT];

    for (genvar p = 0; p < PORT_CNT; p++) begin : g_port
        assign req[p]     = {req_valid_i[p], req_addr_i[p*ADDR_W +: ADDR_W]};
        assign bank_id[p] = get_bank_id(req[p].addr);
        assign row[p]     = get_raddr(req[p].addr);

        // Data mux uses the bank captured at grant time, not the live address.
        assign rsp_data_o[p*DATA_W +: DATA_W] =
            rsp_valid_o[p] ? bank_rdata_i[int'(bank_sel[p])*DATA_W +: DATA_W] : '0;

        a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (req_valid_i[p] && !req_ready_o[p]) |=>
            (req_valid_i[p] && $stable(req_addr_i[p*ADDR_W +: ADDR_W])));
    end

    for (genvar b = 0; b < BANK_CNT; b++) begin : g_bank
        logic [PORT_CNT-1:0] breq;
        logic [PORT_CNT-1:0] rgnt;
        logic [PORT_CNT-1:0] bgnt;
        logic [ROW_W-1:0]    win_row;

        // Gating with rst_n keeps ready/ren low throughout reset.
        always_comb begin
            breq = '0;
            for (int p = 0; p < PORT_CNT; p++) begin
                breq[p] = req[p].valid && (int'(bank_id[p]) == b) && rst_n;
            end
        end

        vpu_rr_arb #(.N(PORT_CNT)) u_rr (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (breq),
            .gnt   (rgnt)
        );

        always_comb begin
            win_row = '0;
            for (int p = 0; p < PORT_CNT; p++) begin
                if (rgnt[p]) win_row = row[p];
            end
        end

`ifdef VPU_RD_ARB_MERGE_EN
        // Riders on the winner's row share its read; the pointer only sees rgnt.
        always_comb begin
            bgnt = '0;
            for (int p = 0; p < PORT_CNT; p++) begin
                bgnt[p] = breq[p] && (|rgnt) && (row[p] == win_row);
            end
        end
`else
        assign bgnt = rgnt;
`endif

        assign bank_gnt[b]                          = bgnt;
        assign bank_ren_o[b]                        = |rgnt;
        assign bank_raddr_o[b*ROW_W +: ROW_W]       = win_row;
    end

    always_comb begin
        req_ready_o = '0;
        for (int b = 0; b < BANK_CNT; b++) begin
            req_ready_o = req_ready_o | bank_gnt[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_o <= '0;
            for (int p = 0; p < PORT_CNT; p++) bank_sel[p] <= '0;
        end else begin
            rsp_valid_o <= req_ready_o;
            for (int p = 0; p < PORT_CNT; p++) begin
                if (req_ready_o[p]) bank_sel[p] <= bank_id[p];
            end
        end
    end

endmodule

// File: tb/tb_vpu_sram_rd_arb.sv
// tb/tb_vpu_sram_rd_arb.sv - directed scoreboard bench for vpu_sram_rd_arb
module tb_vpu_sram_rd_arb;
    localparam int P  = 3;
    localparam int B  = 4;
    localparam int AW = 24;
    localparam int DW = 512;
    localparam int RW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [P-1:0]      valid;
    logic [AW-1:0]     addr [P];
    logic [P*AW-1:0]   req_addr;
    logic [P-1:0]      ready;
    logic [P-1:0]      rsp_valid;
    logic [P*DW-1:0]   rsp_data;
    logic [B-1:0]      ren;
    logic [B*RW-1:0]   raddr;
    logic [B*DW-1:0]   bank_rdata = '0;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [P][$];

    assign req_addr = {addr[2], addr[1], addr[0]};

    always #5 clk = ~clk;

    vpu_sram_rd_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (valid),
        .req_addr_i   (req_addr),
        .req_ready_o  (ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .bank_ren_o   (ren),
        .bank_raddr_o (raddr),
        .bank_rdata_i (bank_rdata)
    );

    function automatic logic [DW-1:0] pat(input logic [1:0] bk, input logic [9:0] r);
        return {16{4'hA, 2'b00, bk, 6'b0, r, 8'h5C}};
    endfunction

    // SRAM model: one-cycle read latency, zero when not read.
    always @(posedge clk) begin
        for (int b = 0; b < B; b++) begin
            bank_rdata[b*DW +: DW] <= ren[b] ? pat(2'(b), raddr[b*RW +: RW]) : '0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare responses first, then record this cycle's handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < P; p++) exp_q[p].delete();
        end else begin
            for (int p = 0; p < P; p++) begin
                if (rsp_valid[p]) begin
                    check($sformatf("rsp_pending%0d", p), 64'(exp_q[p].size() > 0), 64'd1);
                    if (exp_q[p].size() > 0) begin
                        logic [DW-1:0] e;
                        e = exp_q[p].pop_front();
                        checks++;
                        assert (rsp_data[p*DW +: DW] === e) else begin
                            failures++;
                            $error("FAIL rsp_data%0d observed=%0h expected=%0h", p, rsp_data[p*DW +: DW], e);
                        end
                    end
                end else begin
                    checks++;
                    assert (rsp_data[p*DW +: DW] === '0) else begin
                        failures++;
                        $error("FAIL rsp_idle%0d observed=%0h expected=0", p, rsp_data[p*DW +: DW]);
                    end
                end
                if (valid[p] && ready[p])
                    exp_q[p].push_back(pat(addr[p][10:9], addr[p][20:11]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = '0;
        rst_n = 1'b0;
        tick();
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] gseq [4];
        logic [9:0] rseq [4];
        gseq = '{3'b001, 3'b010, 3'b100, 3'b001};
        rseq = '{10'd1, 10'd2, 10'd3, 10'd1};

        valid   = '0;
        addr[0] = '0;
        addr[1] = '0;
        addr[2] = '0;

        // Reset: outputs quiet even with requests pending
        #2;
        valid = 3'b111;
        #1;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_ren", 64'(ren), 64'd0);
        check("rst_rsp", 64'(rsp_valid), 64'd0);
        repeat (2) tick();
        valid = '0;
        rst_n = 1'b1;

        // No conflict: three banks at once
        do_reset();
        addr[0] = 24'h000000; addr[1] = 24'h000200; addr[2] = 24'h000400;
        valid = 3'b111;
        #1;
        check("nc_ready", 64'(ready), 64'b111);
        check("nc_ren", 64'(ren), 64'b0111);
        check("nc_raddr", 64'(raddr), 64'd0);
        tick();
        valid = '0;
        check("nc_rsp", 64'(rsp_valid), 64'b111);
        #1;
        check("nc_ready_off", 64'(ready), 64'd0);

        // Full conflict on bank 0 with valids held: 0,1,2 then back to 0
        do_reset();
        addr[0] = 24'h000800; addr[1] = 24'h001000; addr[2] = 24'h001800;
        valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("fc_ready%0d", i), 64'(ready), 64'(gseq[i]));
            check($sformatf("fc_ren%0d", i), 64'(ren), 64'b0001);
            check($sformatf("fc_raddr%0d", i), 64'(raddr[RW-1:0]), 64'(rseq[i]));
            tick();
            check($sformatf("fc_rsp%0d", i), 64'(rsp_valid), 64'(gseq[i]));
        end
        valid = '0;

        // Fairness and back-to-back on bank 1
        do_reset();
        addr[0] = 24'h000200; addr[2] = 24'h000A00;
        valid = 3'b101;
        #1;
        check("fair_c0", 64'(ready), 64'b001);
        tick();
        #1;
        check("fair_p2", 64'(ready), 64'b100);
        check("fair_raddr", 64'(raddr[2*RW-1:RW]), 64'd1);
        tick();
        valid[2] = 1'b0;
        check("fair_rsp", 64'(rsp_valid), 64'b100);
        #1;
        check("b2b_c2", 64'(ready), 64'b001);
        tick();
        check("b2b_rsp", 64'(rsp_valid), 64'b001);
        #1;
        check("b2b_c3", 64'(ready), 64'b001);
        tick();
        valid = '0;

        // Same-row requests
        do_reset();
        addr[0] = 24'h000800; addr[1] = 24'h000800;
        valid = 3'b011;
        #1;
`ifdef VPU_RD_ARB_MERGE_EN
        check("mg_ready", 64'(ready), 64'b011);
        check("mg_ren", 64'(ren), 64'b0001);
        check("mg_raddr", 64'(raddr[RW-1:0]), 64'd1);
        tick();
        valid = '0;
        check("mg_rsp", 64'(rsp_valid), 64'b011);
`else
        check("ser_ready0", 64'(ready), 64'b001);
        check("ser_ren", 64'(ren), 64'b0001);
        tick();
        valid[0] = 1'b0;
        check("ser_rsp0", 64'(rsp_valid), 64'b001);
        #1;
        check("ser_ready1", 64'(ready), 64'b010);
        tick();
        valid = '0;
        check("ser_rsp1", 64'(rsp_valid), 64'b010);
`endif

        // Reset the cycle after a grant: response dropped, pointer cleared
        do_reset();
        addr[0] = 24'h000200;
        valid = 3'b001;
        #1;
        check("mr_ready", 64'(ready), 64'b001);
        tick();
        valid = '0;
        rst_n = 1'b0;
        #1;
        check("mr_rsp_low", 64'(rsp_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_rsp_after", 64'(rsp_valid), 64'd0);
        addr[0] = 24'h000200; addr[1] = 24'h000A00;
        valid = 3'b011;
        #1;
        check("mr_ptr0", 64'(ready), 64'b001);
        tick();
        valid[0] = 1'b0;
        #1;
        check("mr_ptr1", 64'(ready), 64'b010);
        tick();
        valid = '0;

        // Upper address bits ignored
        do_reset();
        addr[0] = 24'hFFFFFF; addr[1] = 24'hE00200;
        valid = 3'b011;
        #1;
        check("ub_ready", 64'(ready), 64'b011);
        check("ub_ren", 64'(ren), 64'b1010);
        check("ub_raddr1", 64'(raddr[2*RW-1:RW]), 64'd0);
        check("ub_raddr3", 64'(raddr[4*RW-1:3*RW]), 64'h3FF);
        tick();
        valid = '0;
        check("ub_rsp", 64'(rsp_valid), 64'b011);

        repeat (2) tick();
        for (int p = 0; p < P; p++)
            check($sformatf("sb_empty%0d", p), 64'(exp_q[p].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
